// File: rtl/textcon_if.sv
// Character-input and text-RAM write bus of the text console controller.
// master = character source / tram side, slave = textcon.
interface textcon_if #(
  parameter int unsigned TRAM_ADDRW = 11,
  parameter int unsigned WORD       = 32,
  parameter int unsigned BYTE_CNT   = 4
);
  logic [7:0]            char_in;
  logic                  char_valid;
  logic                  char_ready;
  logic [7:0]            colr;
  logic                  clear;
  logic [BYTE_CNT-1:0]   tram_we;
  logic [TRAM_ADDRW-1:0] tram_addr;
  logic [WORD-1:0]       tram_din;

  modport master (
    output char_in, char_valid, colr, clear,
    input  char_ready, tram_we, tram_addr, tram_din
  );

  modport slave (
    input  char_in, char_valid, colr, clear,
    output char_ready, tram_we, tram_addr, tram_din
  );
endinterface

// File: rtl/textcon.sv
// Text console controller: cursor tracking, wrap, scroll and clear into a text RAM.
// Optional feature: define TEXTCON_BKSP_EN to treat 0x08 as destructive backspace.
module textcon #(
  parameter int unsigned TRAM_ADDRW = 11,
  parameter int unsigned TRAM_HRES  = 84,
  parameter int unsigned TRAM_VRES  = 24,
  parameter int unsigned WORD       = 32,
  parameter int unsigned BYTE_CNT   = 4
) (
  input  logic                  clk_sys,
  input  logic                  rst_sys,
  textcon_if.slave              bus,
  output logic [TRAM_ADDRW-1:0] scroll_offs,
  output logic [7:0]            cur_x,
  output logic [7:0]            cur_y,
  output logic                  busy
);

  localparam int unsigned SCREEN = TRAM_HRES * TRAM_VRES;
  localparam int unsigned WIDE   = TRAM_ADDRW + 18;
  localparam int unsigned CW     = TRAM_ADDRW + 1;

`ifdef TEXTCON_BKSP_EN
  localparam bit BKSP_EN = 1'b1;
`else
  localparam bit BKSP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, WRITE, ADV, CLR_LINE, CLR_ALL} state_t;

  state_t                state, state_d;
  logic [7:0]            colr_q, colr_d;
  logic                  bksp_q, bksp_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [7:0]            x_d, y_d;
  logic [TRAM_ADDRW-1:0] offs_d;
  logic [BYTE_CNT-1:0]   we_d;
  logic [TRAM_ADDRW-1:0] addr_d;
  logic [WORD-1:0]       din_d;
  logic                  nl;

  function automatic logic [TRAM_ADDRW-1:0] wrap(input logic [WIDE-1:0] v);
    return TRAM_ADDRW'(v % WIDE'(SCREEN));
  endfunction

  // Full-width sum before the modulo so offset + row base never truncates.
  function automatic logic [TRAM_ADDRW-1:0] cell_addr(input logic [TRAM_ADDRW-1:0] offs,
                                                       input logic [7:0] x,
                                                       input logic [7:0] y);
    return wrap(WIDE'(offs) + WIDE'(y) * WIDE'(TRAM_HRES) + WIDE'(x));
  endfunction

  function automatic logic [WORD-1:0] cell_word(input logic [7:0] c, input logic [7:0] a);
    return WORD'({a, c});
  endfunction

  assign bus.char_ready = (state == IDLE) && !bus.clear;

  always_comb begin
    state_d = state;
    colr_d  = colr_q;
    bksp_d  = bksp_q;
    cnt_d   = cnt;
    x_d     = cur_x;
    y_d     = cur_y;
    offs_d  = scroll_offs;
    we_d    = '0;
    addr_d  = bus.tram_addr;
    din_d   = bus.tram_din;
    nl      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.clear) begin
          state_d = CLR_ALL;
          colr_d  = bus.colr;
          we_d    = '1;
          addr_d  = '0;
          din_d   = cell_word(8'h20, bus.colr);
          cnt_d   = CW'(1);
        end else if (bus.char_valid) begin
          colr_d = bus.colr;
          bksp_d = 1'b0;
          if (bus.char_in == 8'h0A) begin
            nl = 1'b1;
          end else if (bus.char_in == 8'h0D) begin
            x_d = 8'd0;
          end else if (BKSP_EN && bus.char_in == 8'h08) begin
            bksp_d  = 1'b1;
            x_d     = (cur_x != 8'd0) ? cur_x - 8'd1 : cur_x;
            state_d = WRITE;
            we_d    = '1;
            addr_d  = cell_addr(scroll_offs, x_d, cur_y);
            din_d   = cell_word(8'h20, bus.colr);
          end else begin
            state_d = WRITE;
            we_d    = '1;
            addr_d  = cell_addr(scroll_offs, cur_x, cur_y);
            din_d   = cell_word(bus.char_in, bus.colr);
          end
        end
      end
      WRITE: state_d = bksp_q ? IDLE : ADV;
      ADV: begin
        if (cur_x < 8'(TRAM_HRES - 1)) begin
          x_d     = cur_x + 8'd1;
          state_d = IDLE;
        end else begin
          nl = 1'b1;
        end
      end
      CLR_LINE: begin
        if (cnt < CW'(TRAM_HRES)) begin
          we_d   = '1;
          addr_d = wrap(WIDE'(bus.tram_addr) + WIDE'(1));
          cnt_d  = cnt + CW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      CLR_ALL: begin
        if (cnt < CW'(SCREEN)) begin
          we_d   = '1;
          addr_d = bus.tram_addr + TRAM_ADDRW'(1);
          cnt_d  = cnt + CW'(1);
        end else begin
          state_d = IDLE;
          offs_d  = '0;
          x_d     = 8'd0;
          y_d     = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Newline from LF or last-column wrap; scrolling starts the bottom-row blanking.
    if (nl) begin
      x_d = 8'd0;
      if (cur_y < 8'(TRAM_VRES - 1)) begin
        y_d     = cur_y + 8'd1;
        state_d = IDLE;
      end else begin
        offs_d  = wrap(WIDE'(scroll_offs) + WIDE'(TRAM_HRES));
        state_d = CLR_LINE;
        we_d    = '1;
        addr_d  = cell_addr(offs_d, 8'd0, 8'(TRAM_VRES - 1));
        din_d   = cell_word(8'h20, colr_d);
        cnt_d   = CW'(1);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state         <= IDLE;
      colr_q        <= 8'd0;
      bksp_q        <= 1'b0;
      cnt           <= '0;
      cur_x         <= 8'd0;
      cur_y         <= 8'd0;
      scroll_offs   <= '0;
      bus.tram_we   <= '0;
      bus.tram_addr <= '0;
      bus.tram_din  <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_d;
      colr_q        <= colr_d;
      bksp_q        <= bksp_d;
      cnt           <= cnt_d;
      cur_x         <= x_d;
      cur_y         <= y_d;
      scroll_offs   <= offs_d;
      bus.tram_we   <= we_d;
      bus.tram_addr <= addr_d;
      bus.tram_din  <= din_d;
      busy          <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_textcon.sv
// Directed bench for textcon (84x24 console, 2016-word screen); follows TEXTCON_BKSP_EN if defined.
module tb_textcon;
  localparam int unsigned LIMIT = 10000;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] scroll_offs;
  logic [7:0]  cur_x, cur_y;
  logic        busy;

  textcon_if #(.TRAM_ADDRW(11), .WORD(32), .BYTE_CNT(4)) bus ();

  textcon #(
    .TRAM_ADDRW(11), .TRAM_HRES(84), .TRAM_VRES(24), .WORD(32), .BYTE_CNT(4)
  ) dut (
    .clk_sys    (clk),
    .rst_sys    (rst),
    .bus        (bus),
    .scroll_offs(scroll_offs),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Write monitor, sampled on the falling edge.
  int          wr_total  = 0;
  int          blank_bad = 0;
  int          ready_bad = 0;
  int          we_bad    = 0;
  logic [10:0] first_addr = '0;
  logic [10:0] last_addr  = '0;
  logic [31:0] last_din   = '0;
  logic        prev_we    = 1'b0;
  logic        blank_mode = 1'b0;
  logic [7:0]  exp_colr   = 8'h00;

  always @(negedge clk) begin
    if (bus.tram_we != 4'h0) begin
      wr_total++;
      if (!prev_we) first_addr = bus.tram_addr;
      last_addr = bus.tram_addr;
      last_din  = bus.tram_din;
      if (bus.tram_we != 4'hF) we_bad++;
      if (blank_mode && bus.tram_din != {16'h0, exp_colr, 8'h20}) blank_bad++;
      prev_we = 1'b1;
    end else begin
      prev_we = 1'b0;
    end
    if (busy && bus.char_ready) ready_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || !bus.char_ready) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n >= LIMIT), 32'd0);
    #2;
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] col);
    @(negedge clk);
    bus.char_in    = c;
    bus.colr       = col;
    bus.char_valid = 1'b1;
    @(negedge clk);
    bus.char_valid = 1'b0;
  endtask

  task automatic send_wait(input logic [7:0] c, input logic [7:0] col);
    send(c, col);
    wait_idle();
  endtask

  int base_wr;
  int base_rdy;

  initial begin
    rst            = 1'b1;
    bus.char_in    = 8'h00;
    bus.char_valid = 1'b0;
    bus.colr       = 8'h00;
    bus.clear      = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #2;
    chk("rst_ready", 32'(bus.char_ready), 32'd1);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_we",    32'(bus.tram_we), 32'd0);
    chk("rst_cur",   {16'h0, cur_x, cur_y}, 32'd0);
    chk("rst_offs",  32'(scroll_offs), 32'd0);

    // Single printable character
    base_wr = wr_total;
    send(8'h41, 8'h1F);
    chk("a_we_next_cycle", 32'(bus.tram_we), 32'hF);
    wait_idle();
    chk("a_wr_cnt", 32'(wr_total - base_wr), 32'd1);
    chk("a_addr",   32'(last_addr), 32'd0);
    chk("a_din",    last_din, 32'h0000_1F41);
    chk("a_cur",    {16'h0, cur_x, cur_y}, {16'h0, 8'd1, 8'd0});

    // Fill the rest of row 0 and wrap
    base_wr = wr_total;
    for (int i = 0; i < 83; i++) send_wait(8'(8'h61 + i % 26), 8'h07);
    chk("row_wr_cnt", 32'(wr_total - base_wr), 32'd83);
    chk("row_last_addr", 32'(last_addr), 32'd83);
    chk("row_cur", {16'h0, cur_x, cur_y}, {16'h0, 8'd0, 8'd1});

    // Carriage return: no write
    send_wait(8'h58, 8'h07);
    chk("x_addr", 32'(last_addr), 32'd84);
    base_wr = wr_total;
    send_wait(8'h0D, 8'h07);
    chk("cr_no_write", 32'(wr_total - base_wr), 32'd0);
    chk("cr_cur", {16'h0, cur_x, cur_y}, {16'h0, 8'd0, 8'd1});

    // Backspace at (5,2)
    send_wait(8'h0A, 8'h07);
    for (int i = 0; i < 5; i++) send_wait(8'h68, 8'h07);
    chk("pre_bs_addr", 32'(last_addr), 32'd172);
    chk("pre_bs_cur", {16'h0, cur_x, cur_y}, {16'h0, 8'd5, 8'd2});
    base_wr = wr_total;
    send_wait(8'h08, 8'h3C);
    chk("bs_wr_cnt", 32'(wr_total - base_wr), 32'd1);
`ifdef TEXTCON_BKSP_EN
    chk("bs_addr", 32'(last_addr), 32'd172);
    chk("bs_din",  last_din, 32'h0000_3C20);
    chk("bs_cur_x", 32'(cur_x), 32'd4);
`else
    chk("bs_addr", 32'(last_addr), 32'd173);
    chk("bs_din",  last_din, 32'h0000_3C08);
    chk("bs_cur_x", 32'(cur_x), 32'd6);
`endif

    // Walk down to the bottom row
    base_wr = wr_total;
    for (int i = 0; i < 21; i++) send_wait(8'h0A, 8'h07);
    chk("lf_no_write", 32'(wr_total - base_wr), 32'd0);
    chk("bottom_cur", {16'h0, cur_x, cur_y}, {16'h0, 8'd0, 8'd23});

    // First scroll: bottom row at 2016..2099 mod 2016
    blank_mode = 1'b1;
    exp_colr   = 8'h5A;
    base_wr    = wr_total;
    send_wait(8'h0A, 8'h5A);
    chk("scr_offs",   32'(scroll_offs), 32'd84);
    chk("scr_wr_cnt", 32'(wr_total - base_wr), 32'd84);
    chk("scr_first",  32'(first_addr), 32'd0);
    chk("scr_last",   32'(last_addr), 32'd83);
    chk("scr_din",    last_din, 32'h0000_5A20);
    chk("scr_cur",    {16'h0, cur_x, cur_y}, {16'h0, 8'd0, 8'd23});

    // Scroll up to offset 1932, then wrap to 0
    for (int i = 0; i < 22; i++) send_wait(8'h0A, 8'h5A);
    chk("offs_1932", 32'(scroll_offs), 32'd1932);
    send_wait(8'h0A, 8'h5A);
    chk("offs_wrap",  32'(scroll_offs), 32'd0);
    chk("wrap_first", 32'(first_addr), 32'd1932);
    chk("wrap_last",  32'(last_addr), 32'd2015);
    chk("blank_din",  32'(blank_bad), 32'd0);
    blank_mode = 1'b0;

    // Printing off the last column of the bottom row scrolls
    base_wr = wr_total;
    for (int i = 0; i < 84; i++) send_wait(8'h5A, 8'h0E);
    chk("wrapscr_wr_cnt", 32'(wr_total - base_wr), 32'd168);
    chk("wrapscr_offs",   32'(scroll_offs), 32'd84);
    chk("wrapscr_last",   32'(last_addr), 32'd83);
    chk("wrapscr_din",    last_din, 32'h0000_0E20);
    chk("wrapscr_cur",    {16'h0, cur_x, cur_y}, {16'h0, 8'd0, 8'd23});

    // Clear beats a simultaneous character
    blank_mode = 1'b1;
    exp_colr   = 8'h71;
    base_wr    = wr_total;
    base_rdy   = ready_bad;
    @(negedge clk);
    bus.clear      = 1'b1;
    bus.char_valid = 1'b1;
    bus.char_in    = 8'h51;
    bus.colr       = 8'h71;
    #1;
    chk("clr_ready_low", 32'(bus.char_ready), 32'd0);
    @(negedge clk);
    bus.clear      = 1'b0;
    bus.char_valid = 1'b0;
    chk("clr_busy", 32'(busy), 32'd1);
    wait_idle();
    chk("clr_wr_cnt", 32'(wr_total - base_wr), 32'd2016);
    chk("clr_first",  32'(first_addr), 32'd0);
    chk("clr_last",   32'(last_addr), 32'd2015);
    chk("clr_din",    32'(blank_bad), 32'd0);
    chk("clr_ready",  32'(ready_bad - base_rdy), 32'd0);
    chk("clr_cur",    {16'h0, cur_x, cur_y}, 32'd0);
    chk("clr_offs",   32'(scroll_offs), 32'd0);
    blank_mode = 1'b0;

    // Reset in the middle of a full clear
    base_wr = wr_total;
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #2;
    chk("midclr_started", 32'((wr_total - base_wr) >= 90), 32'd1);
    base_wr = wr_total;
    repeat (4) @(negedge clk);
    #2;
    chk("abort_no_write", 32'(wr_total - base_wr), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #2;
    chk("abort_ready", 32'(bus.char_ready), 32'd1);
    chk("abort_cur", {16'h0, cur_x, cur_y}, 32'd0);

    chk("we_all_ones", 32'(we_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
